graphics_command_framer: RTL and testbench

- Converts the SPI byte stream into the op-code/operand stream consumed by the graphics block.
- The first byte of each chip-select transaction is the op-code. Every following byte is an operand, tagged with a running count.
- Sits between the SPI peripheral's byte receiver and the graphics command decoder.
- Guarantees the framing rules the decoder relies on:
  - op_code_valid is held for the whole transaction.
  - operand_valid pulses exactly once per operand.
  - op_code_valid drops for at least one cycle between transactions.

---
 rtl/graphics_pkg.sv | 19 +
 rtl/graphics_command_framer.sv | 144 ++++++++++++++
 tb/tb_graphics_command_framer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/graphics_pkg.sv
// Shared definitions for the graphics command path: op-codes, framer states, count width.
package graphics_pkg;

    localparam logic [7:0] CLEAR_BUFFER = 8'h10;
    localparam logic [7:0] ASSIGN_COLOR = 8'h11;
    localparam logic [7:0] DRAW_SPRITE  = 8'h12;
    localparam logic [7:0] SHOW_BUFFER  = 8'h14;

    localparam int COUNT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_OPCODE,
        OPERANDS,
        GAP,
        DRAIN
    } framer_state_t;

endpackage

// File: rtl/graphics_command_framer.sv
// Frames the SPI byte stream into an op-code plus counted operand strobes for the graphics decoder.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | no transaction; waits for chip-select (after reset, cs must drop first)
// WAIT_OPCODE | chip-select active, first byte not yet received
// OPERANDS    | op-code valid; each further byte is a counted operand
// GAP         | forced op_code_valid low; an early op-code byte is held in a buffer
// DRAIN       | transaction discarded until chip-select drops
module graphics_command_framer
    import graphics_pkg::*;
#(
    parameter int MAX_OPERANDS = 65535,
    parameter int GAP_CYCLES   = 1
) (
    input  logic               clock_in,
    input  logic               reset_in,
    input  logic               cs_active_in,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid_in,
    output logic [7:0]         op_code_out,
    output logic               op_code_valid_out,
    output logic [7:0]         operand_out,
    output logic               operand_valid_out,
    output logic [COUNT_W-1:0] operand_count_out,
    output logic               overflow_out
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    framer_state_t    state;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       hold_byte;
    logic             hold_full;
    logic             cs_q;
    logic             armed;

    // A byte in the same cycle chip-select falls still counts as the last operand.
    logic accept_operand;
    assign accept_operand = byte_valid_in && (cs_active_in || cs_q);

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state             <= IDLE;
            op_code_out       <= '0;
            op_code_valid_out <= 1'b0;
            operand_out       <= '0;
            operand_valid_out <= 1'b0;
            operand_count_out <= '0;
            overflow_out      <= 1'b0;
            gap_cnt           <= '0;
            hold_byte         <= '0;
            hold_full         <= 1'b0;
            cs_q              <= 1'b0;
            // A reset inside a live transaction must not re-frame its remaining bytes.
            armed             <= ~cs_active_in;
        end else begin
            cs_q              <= cs_active_in;
            operand_valid_out <= 1'b0;
            if (!cs_active_in) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_active_in && armed) begin
                        if (byte_valid_in) begin
                            op_code_out       <= byte_in;
                            op_code_valid_out <= 1'b1;
                            operand_count_out <= '0;
                            state             <= OPERANDS;
                        end else begin
                            state <= WAIT_OPCODE;
                        end
                    end
                end

                WAIT_OPCODE: begin
                    if (!cs_active_in) begin
                        state <= IDLE;
                    end else if (byte_valid_in) begin
                        op_code_out       <= byte_in;
                        op_code_valid_out <= 1'b1;
                        operand_count_out <= '0;
                        state             <= OPERANDS;
                    end
                end

                OPERANDS: begin
                    if (accept_operand) begin
                        if (operand_count_out == COUNT_W'(MAX_OPERANDS)) begin
                            overflow_out <= 1'b1;
                        end else begin
                            operand_out       <= byte_in;
                            operand_valid_out <= 1'b1;
                            operand_count_out <= operand_count_out + COUNT_W'(1);
                        end
                    end else if (!cs_active_in) begin
                        op_code_valid_out <= 1'b0;
                        overflow_out      <= 1'b0;
                        operand_count_out <= '0;
                        hold_full         <= 1'b0;
                        gap_cnt           <= GAP_W'(GAP_CYCLES - 1);
                        state             <= GAP;
                    end
                end

                GAP: begin
                    if (cs_active_in && byte_valid_in && hold_full) begin
                        hold_full <= 1'b0;
                        state     <= DRAIN;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                        if (cs_active_in && byte_valid_in) begin
                            hold_byte <= byte_in;
                            hold_full <= 1'b1;
                        end
                    end else begin
                        hold_full <= 1'b0;
                        if (!cs_active_in) begin
                            state <= IDLE;
                        end else if (hold_full || byte_valid_in) begin
                            op_code_out       <= hold_full ? hold_byte : byte_in;
                            op_code_valid_out <= 1'b1;
                            operand_count_out <= '0;
                            state             <= OPERANDS;
                        end else begin
                            state <= WAIT_OPCODE;
                        end
                    end
                end

                DRAIN: begin
                    if (!cs_active_in) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_graphics_command_framer.sv
// Directed bench: vector table against a default-parameter framer, hand sequences for saturation and gap buffering.
module tb_graphics_command_framer;

    logic        clock_in;
    logic        reset_in;
    logic        cs_active_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;

    logic [7:0]  a_op, b_op;
    logic        a_opv, b_opv;
    logic [7:0]  a_opd, b_opd;
    logic        a_opdv, b_opdv;
    logic [31:0] a_cnt, b_cnt;
    logic        a_ovf, b_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    graphics_command_framer #(.MAX_OPERANDS(65535), .GAP_CYCLES(1)) dut_a (
        .clock_in          (clock_in),
        .reset_in          (reset_in),
        .cs_active_in      (cs_active_in),
        .byte_in           (byte_in),
        .byte_valid_in     (byte_valid_in),
        .op_code_out       (a_op),
        .op_code_valid_out (a_opv),
        .operand_out       (a_opd),
        .operand_valid_out (a_opdv),
        .operand_count_out (a_cnt),
        .overflow_out      (a_ovf)
    );

    graphics_command_framer #(.MAX_OPERANDS(3), .GAP_CYCLES(3)) dut_b (
        .clock_in          (clock_in),
        .reset_in          (reset_in),
        .cs_active_in      (cs_active_in),
        .byte_in           (byte_in),
        .byte_valid_in     (byte_valid_in),
        .op_code_out       (b_op),
        .op_code_valid_out (b_opv),
        .operand_out       (b_opd),
        .operand_valid_out (b_opdv),
        .operand_count_out (b_cnt),
        .overflow_out      (b_ovf)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        logic        rst, cs, bv;
        logic [7:0]  b;
        logic [7:0]  op;
        logic        opv;
        logic [7:0]  opd;
        logic        opdv;
        logic [31:0] cnt;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic cs, input logic bv, input logic [7:0] b,
                       input logic [7:0] op, input logic opv, input logic [7:0] opd,
                       input logic opdv, input int cnt, input logic ovf);
        vec_t v;
        v.rst = rst; v.cs = cs; v.bv = bv; v.b = b;
        v.op = op; v.opv = opv; v.opd = opd; v.opdv = opdv; v.cnt = cnt; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic rst, input logic cs, input logic bv, input logic [7:0] b);
        @(negedge clock_in);
        reset_in      = rst;
        cs_active_in  = cs;
        byte_valid_in = bv;
        byte_in       = b;
        @(posedge clock_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [50:0] act, exp;

        reset_in = 1'b1; cs_active_in = 1'b0; byte_valid_in = 1'b0; byte_in = 8'h00;

        //   rst cs bv byte   | op    opv opd   opdv cnt ovf
        add(1, 0, 0, 8'h00,  8'h00, 0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 8'h00,  8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 8'h00,  8'h00, 0, 8'h00, 0, 0, 0);
        // op-code with four operands
        add(0, 1, 1, 8'h11,  8'h11, 1, 8'h00, 0, 0, 0);
        add(0, 1, 1, 8'h05,  8'h11, 1, 8'h05, 1, 1, 0);
        add(0, 1, 0, 8'h00,  8'h11, 1, 8'h05, 0, 1, 0);
        add(0, 1, 1, 8'hF0,  8'h11, 1, 8'hF0, 1, 2, 0);
        add(0, 1, 1, 8'hA0,  8'h11, 1, 8'hA0, 1, 3, 0);
        add(0, 1, 1, 8'hE0,  8'h11, 1, 8'hE0, 1, 4, 0);
        add(0, 1, 0, 8'h00,  8'h11, 1, 8'hE0, 0, 4, 0);
        add(0, 0, 0, 8'h00,  8'h11, 0, 8'hE0, 0, 0, 0);
        add(0, 0, 0, 8'h00,  8'h11, 0, 8'hE0, 0, 0, 0);
        add(0, 0, 0, 8'h00,  8'h11, 0, 8'hE0, 0, 0, 0);
        // op-code only, then an empty transaction, then a stray byte with cs low
        add(0, 1, 0, 8'h00,  8'h11, 0, 8'hE0, 0, 0, 0);
        add(0, 1, 1, 8'h10,  8'h10, 1, 8'hE0, 0, 0, 0);
        add(0, 1, 0, 8'h00,  8'h10, 1, 8'hE0, 0, 0, 0);
        add(0, 0, 0, 8'h00,  8'h10, 0, 8'hE0, 0, 0, 0);
        add(0, 0, 0, 8'h00,  8'h10, 0, 8'hE0, 0, 0, 0);
        add(0, 1, 0, 8'h00,  8'h10, 0, 8'hE0, 0, 0, 0);
        add(0, 1, 0, 8'h00,  8'h10, 0, 8'hE0, 0, 0, 0);
        add(0, 0, 0, 8'h00,  8'h10, 0, 8'hE0, 0, 0, 0);
        add(0, 0, 1, 8'h55,  8'h10, 0, 8'hE0, 0, 0, 0);
        // back-to-back: next op-code arrives in the one-cycle gap
        add(0, 1, 1, 8'h11,  8'h11, 1, 8'hE0, 0, 0, 0);
        add(0, 1, 1, 8'h22,  8'h11, 1, 8'h22, 1, 1, 0);
        add(0, 0, 0, 8'h00,  8'h11, 0, 8'h22, 0, 0, 0);
        add(0, 1, 1, 8'h14,  8'h14, 1, 8'h22, 0, 0, 0);
        add(0, 1, 1, 8'h33,  8'h14, 1, 8'h33, 1, 1, 0);
        // last operand coincides with cs fall
        add(0, 0, 1, 8'h44,  8'h14, 1, 8'h44, 1, 2, 0);
        add(0, 0, 0, 8'h00,  8'h14, 0, 8'h44, 0, 0, 0);
        add(0, 0, 0, 8'h00,  8'h14, 0, 8'h44, 0, 0, 0);
        // reset after operand 2; rest of that transaction ignored
        add(0, 1, 1, 8'h12,  8'h12, 1, 8'h44, 0, 0, 0);
        add(0, 1, 1, 8'h01,  8'h12, 1, 8'h01, 1, 1, 0);
        add(0, 1, 1, 8'h02,  8'h12, 1, 8'h02, 1, 2, 0);
        add(1, 1, 1, 8'h03,  8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 1, 1, 8'h04,  8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 1, 1, 8'h05,  8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 1, 1, 8'h06,  8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 8'h00,  8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 1, 1, 8'h10,  8'h10, 1, 8'h00, 0, 0, 0);
        add(0, 1, 1, 8'h77,  8'h10, 1, 8'h77, 1, 1, 0);
        add(0, 0, 0, 8'h00,  8'h10, 0, 8'h77, 0, 0, 0);
        add(0, 0, 0, 8'h00,  8'h10, 0, 8'h77, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].cs, vecs[i].bv, vecs[i].b);
            act = {a_op, a_opv, a_opd, a_opdv, a_cnt, a_ovf};
            exp = {vecs[i].op, vecs[i].opv, vecs[i].opd, vecs[i].opdv, vecs[i].cnt, vecs[i].ovf};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got op=%h opv=%b opd=%h opdv=%b cnt=%0d ovf=%b, expected op=%h opv=%b opd=%h opdv=%b cnt=%0d ovf=%b",
                         i, a_op, a_opv, a_opd, a_opdv, a_cnt, a_ovf,
                         vecs[i].op, vecs[i].opv, vecs[i].opd, vecs[i].opdv, vecs[i].cnt, vecs[i].ovf);
            end
        end

        // Saturation on the MAX_OPERANDS=3, GAP_CYCLES=3 instance
        drive(1, 0, 0, 8'h00);
        drive(0, 0, 0, 8'h00);
        chk("b_reset_opv", 32'(b_opv), 32'd0);
        drive(0, 1, 1, 8'h12);
        chk("b_sat_op", 32'(b_op), 32'h12);
        chk("b_sat_opv", 32'(b_opv), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, 1, 8'(k));
            chk($sformatf("b_sat_cnt%0d", k), b_cnt, (k <= 3) ? 32'(k) : 32'd3);
            chk($sformatf("b_sat_strobe%0d", k), 32'(b_opdv), (k <= 3) ? 32'd1 : 32'd0);
            chk($sformatf("b_sat_data%0d", k), 32'(b_opd), (k <= 3) ? 32'(k) : 32'd3);
            chk($sformatf("b_sat_ovf%0d", k), 32'(b_ovf), (k <= 3) ? 32'd0 : 32'd1);
        end
        drive(0, 0, 0, 8'h00);
        chk("b_close_ovf", 32'(b_ovf), 32'd0);
        chk("b_close_cnt", b_cnt, 32'd0);
        chk("b_close_opv", 32'(b_opv), 32'd0);

        // Three-cycle gap with an early op-code held and presented on exit
        drive(0, 1, 1, 8'h14);
        chk("b_gap1_opv", 32'(b_opv), 32'd0);
        drive(0, 1, 0, 8'h00);
        chk("b_gap2_opv", 32'(b_opv), 32'd0);
        drive(0, 1, 0, 8'h00);
        chk("b_gap_exit_opv", 32'(b_opv), 32'd1);
        chk("b_gap_exit_op", 32'(b_op), 32'h14);
        chk("b_gap_exit_cnt", b_cnt, 32'd0);

        // Two bytes inside the gap: transaction dropped until cs falls
        drive(0, 0, 0, 8'h00);
        chk("b_drop_close_opv", 32'(b_opv), 32'd0);
        drive(0, 1, 1, 8'hAA);
        drive(0, 1, 1, 8'hBB);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, (k < 2) ? 1'b1 : 1'b0, 8'hCC);
            chk($sformatf("b_drain_opv%0d", k), 32'(b_opv), 32'd0);
            chk($sformatf("b_drain_opdv%0d", k), 32'(b_opdv), 32'd0);
            chk($sformatf("b_drain_op%0d", k), 32'(b_op), 32'h14);
        end
        drive(0, 0, 0, 8'h00);
        drive(0, 0, 0, 8'h00);
        drive(0, 1, 1, 8'h10);
        chk("b_after_drain_opv", 32'(b_opv), 32'd1);
        chk("b_after_drain_op", 32'(b_op), 32'h10);
        drive(0, 1, 1, 8'h99);
        chk("b_after_drain_cnt", b_cnt, 32'd1);
        chk("b_after_drain_opd", 32'(b_opd), 32'h99);
        drive(0, 0, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
